fir_tile_sched: RTL and testbench
=================================

# fir_tile_sched

Tile scheduler for the FIR HWPE. It sits between the controller FSM and the streamers/datapath. It splits one offloaded job (signal of `signal_length` 16-bit samples) into tiles of at most `TILE_LEN` output samples. For each tile it issues one streamer start with its own base addresses, lengths and warm-up skip count, waits for the tile to complete, then advances. Input tiles after the first overlap the previous tile by `H_EVEN` samples so the filter history is rebuilt.

## Interface
Clock `clk_i`; reset `rst_ni` is synchronous and active-low.

Parameters:
- `NB_TAPS`, 50: filter taps. Derived localparam `H_EVEN` = (NB_TAPS-1) rounded up to even (50 for default).
- `TILE_LEN`, 256: max output samples per tile; must be even and ≥2.

Ports:
- `clk_i`  in  1  clock
- `rst_ni`  in  1  synchronous active-low reset
- `clear_i`  in  1  synchronous soft clear; same effect as reset
- `start_i`  in  1  job start pulse; sampled only in IDLE
- `x_addr_i`  in  32  X base byte address, 4-byte aligned
- `y_addr_i`  in  32  Y base byte address, 4-byte aligned
- `signal_length_i`  in  16  job length in samples
- `tile_done_i`  in  1  pulse: current tile's Y sink done
- `busy_o`  out  1  high in any state except IDLE
- `done_o`  out  1  one-cycle pulse: job complete
- `tile_start_o`  out  1  one-cycle pulse: start X/H/Y streamers for the tile
- `tile_first_o`  out  1  high while tile 0 is current (tap reload, serdes clear)
- `tile_x_addr_o`  out  32  X tile base byte address
- `tile_x_len_o`  out  16  X tile length in 32-bit words
- `tile_y_addr_o`  out  32  Y tile base byte address
- `tile_y_len_o`  out  16  Y tile length in 32-bit words
- `tile_skip_o`  out  16  leading datapath outputs to drop (0 or `H_EVEN`)
- `tile_idx_o`  out  16  current tile index

## Operation
- FSM states are IDLE, ISSUE, WAIT and DONE.
- **IDLE:** on `start_i`, latch `x_addr_i`, `y_addr_i` and `signal_length_i`; set `off_q`=0 and `rem_q`=length; set `idx_q`=0.
  - If length==0, go to DONE.
  - Otherwise go to ISSUE.
- **ISSUE:** `tile_start_o`=1 for exactly this cycle; go to WAIT unconditionally.
- **WAIT:** on `tile_done_i`, update `off_q`+=TILE_LEN, `rem_q`-=`cur`, `idx_q`+=1.
  - If the new `rem_q`==0, go to DONE.
  - Otherwise go to ISSUE.
- **DONE:** `done_o`=1 for exactly this cycle; go to IDLE.
- Per-tile values are Moore outputs, held constant through ISSUE and WAIT:
  - `cur` = min(`rem_q`, TILE_LEN); `skip` = (`off_q`==0) ? 0 : H_EVEN.
  - `tile_x_addr_o` = x_base + 2·(`off_q` − `skip`).
  - `tile_x_len_o` = ceil((`cur`+`skip`)/2).
  - `tile_y_addr_o` = y_base + 2·`off_q`; `tile_y_len_o` = ceil(`cur`/2).
  - `tile_skip_o` = `skip`; `tile_first_o` = (`idx_q`==0) && `busy_o`.
- Width rules:
  - `off_q` and `rem_q` are 17 bits, which covers 65535+TILE_LEN.
  - Address sums are modulo 2^32.
  - Alignment holds by construction: TILE_LEN and H_EVEN are even.
- Ignored inputs:
  - `start_i` outside IDLE (no re-latch, no effect).
  - `tile_done_i` outside WAIT.
  - `tile_done_i` in the same cycle as `tile_start_o`.
- `clear_i` or reset in any state:
  - Next cycle: IDLE, all counters 0.
  - No `done_o`, no `tile_start_o`.
  - `clear_i` has priority over `start_i`.

## Timing
- Reset/clear values: `busy_o`, `done_o`, `tile_start_o` and `tile_first_o` = 0; all address/length/skip/idx outputs = 0.
- Sequence:
  - `start_i` at cycle t (IDLE): ISSUE with `tile_start_o` at t+1; WAIT at t+2.
  - `tile_done_i` at cycle u (WAIT): at u+1 either ISSUE (next tile) or DONE with `done_o`; IDLE at u+2 after DONE.
- Zero-length job: `done_o` at t+1, no tile pulse.
- Back-to-back jobs: a new `start_i` is accepted in the first IDLE cycle after DONE.
- All outputs are registered or decoded from registered state only. There is no combinational path from `tile_done_i` or `start_i` to any output.

## Structure
- `fir_package` gains:
  - `fir_tile_state_t` (IDLE/ISSUE/WAIT/DONE enum);
  - `fir_tile_ctrl_t` packed struct bundling the tile outputs (`start`, `first`, `x_addr`, `x_len`, `y_addr`, `y_len`, `skip`, `idx`) for `fir_ctrl` to consume;
  - constant `FIR_TILE_LEN`.
- Single module; no sub-module needed. The arithmetic is small, and min/ceil stay inline.

## Test plan
All scenarios use defaults NB_TAPS=50 (H_EVEN=50), TILE_LEN=256, x=0x1000, y=0x2000.
- **Single tile:** length 100.
  - Tile: x 0x1000, xlen 50, y 0x2000, ylen 50, skip 0, first=1.
  - `done_o` one cycle after `tile_done_i`.
- **Multi-tile, even remainder:** length 600 gives three tiles.
  - Tile 0: (0x1000, 128 / 0x2000, 128, skip 0).
  - Tile 1: (0x119C, 153 / 0x2200, 128, skip 50).
  - Tile 2: (0x139C, 69 / 0x2400, 44, skip 50).
  - `tile_idx_o` reads 0, 1, 2.
- **Odd remainder:** length 257.
  - Tile 1: x 0x119C, xlen 26, ylen 1, skip 50.
- **Zero length:** `start_i` → `done_o` at t+1, `busy_o` high exactly one cycle, no `tile_start_o`.
- **Spurious inputs:**
  - `start_i` during WAIT: addresses unchanged.
  - `tile_done_i` in IDLE: no effect.
  - `tile_done_i` in the ISSUE cycle: ignored.
- **Clear and reset mid-job:** `clear_i` in WAIT of tile 1.
  - IDLE next cycle, all outputs 0, no `done_o`.
  - A new job then runs correctly from tile 0.
  - Repeat with `rst_ni` low for one cycle.

Source files
------------

// File: rtl/fir_package.sv
// Shared FIR HWPE types: tile scheduler state, tile control bundle and default tile size.
package fir_package;

    localparam int unsigned FIR_TILE_LEN = 256;

    typedef enum logic [1:0] {
        TILE_IDLE,
        TILE_ISSUE,
        TILE_WAIT,
        TILE_DONE
    } fir_tile_state_t;

    typedef struct packed {
        logic        start;
        logic        first;
        logic [31:0] x_addr;
        logic [15:0] x_len;
        logic [31:0] y_addr;
        logic [15:0] y_len;
        logic [15:0] skip;
        logic [15:0] idx;
    } fir_tile_ctrl_t;

endpackage

// File: rtl/fir_tile_sched.sv
// Splits one FIR job into tiles of at most TILE_LEN outputs; input tiles after
// the first re-read H_EVEN history samples whose outputs the datapath drops.
module fir_tile_sched
    import fir_package::*;
#(
    parameter int unsigned NB_TAPS  = 50,
    parameter int unsigned TILE_LEN = FIR_TILE_LEN
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        clear_i,
    input  logic        start_i,
    input  logic [31:0] x_addr_i,
    input  logic [31:0] y_addr_i,
    input  logic [15:0] signal_length_i,
    input  logic        tile_done_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        tile_start_o,
    output logic        tile_first_o,
    output logic [31:0] tile_x_addr_o,
    output logic [15:0] tile_x_len_o,
    output logic [31:0] tile_y_addr_o,
    output logic [15:0] tile_y_len_o,
    output logic [15:0] tile_skip_o,
    output logic [15:0] tile_idx_o
);

    localparam int unsigned H_EVEN = (NB_TAPS - 1) + ((NB_TAPS - 1) % 2);
    localparam logic [16:0] TILE   = 17'(TILE_LEN);

    fir_tile_state_t state_q, state_d;
    fir_tile_ctrl_t  ctrl;

    logic [16:0] off_q, rem_q, cur, rem_next;
    logic [15:0] idx_q, skip;
    logic [31:0] x_base_q, y_base_q;
    logic [30:0] x_word;

    always_ff @(posedge clk_i) begin
        if (!rst_ni || clear_i) state_q <= TILE_IDLE;
        else                    state_q <= state_d;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni || clear_i) begin
            off_q    <= '0;
            rem_q    <= '0;
            idx_q    <= '0;
            x_base_q <= '0;
            y_base_q <= '0;
        end else if (state_q == TILE_IDLE && start_i) begin
            off_q    <= '0;
            rem_q    <= {1'b0, signal_length_i};
            idx_q    <= '0;
            x_base_q <= x_addr_i;
            y_base_q <= y_addr_i;
        end else if (state_q == TILE_WAIT && tile_done_i) begin
            off_q <= off_q + TILE;
            rem_q <= rem_next;
            idx_q <= idx_q + 16'd1;
        end
    end

    always_comb begin
        state_d  = state_q;
        cur      = (rem_q < TILE) ? rem_q : TILE;
        skip     = (off_q == '0) ? '0 : 16'(H_EVEN);
        rem_next = rem_q - cur;
        // word offset may go negative when TILE_LEN < H_EVEN; wraps modulo 2^32
        x_word   = 31'(off_q) - 31'(skip);
        ctrl     = '0;

        unique case (state_q)
            TILE_IDLE:  if (start_i) state_d = (signal_length_i == '0) ? TILE_DONE : TILE_ISSUE;
            TILE_ISSUE: state_d = TILE_WAIT;
            TILE_WAIT:  if (tile_done_i) state_d = (rem_next == '0) ? TILE_DONE : TILE_ISSUE;
            TILE_DONE:  state_d = TILE_IDLE;
            default:    state_d = TILE_IDLE;
        endcase

        ctrl.start = (state_q == TILE_ISSUE);
        ctrl.first = (idx_q == '0) && (state_q != TILE_IDLE);
        if (state_q == TILE_ISSUE || state_q == TILE_WAIT) begin
            ctrl.x_addr = x_base_q + {x_word, 1'b0};
            ctrl.x_len  = 16'((18'(cur) + 18'(skip) + 18'd1) >> 1);
            ctrl.y_addr = y_base_q + {14'd0, off_q, 1'b0};
            ctrl.y_len  = 16'((18'(cur) + 18'd1) >> 1);
            ctrl.skip   = skip;
            ctrl.idx    = idx_q;
        end
    end

    assign busy_o        = (state_q != TILE_IDLE);
    assign done_o        = (state_q == TILE_DONE);
    assign tile_start_o  = ctrl.start;
    assign tile_first_o  = ctrl.first;
    assign tile_x_addr_o = ctrl.x_addr;
    assign tile_x_len_o  = ctrl.x_len;
    assign tile_y_addr_o = ctrl.y_addr;
    assign tile_y_len_o  = ctrl.y_len;
    assign tile_skip_o   = ctrl.skip;
    assign tile_idx_o    = ctrl.idx;

endmodule

// File: tb/tb_fir_tile_sched.sv
// Self-checking bench for fir_tile_sched: job-level reference model plus
// directed scenarios with hand-computed tile descriptors.
module tb_fir_tile_sched;

    localparam int TL = 256;
    localparam int HE = 50;

    logic        clk = 1'b0;
    logic        rst_n, clear, start, tile_done;
    logic [31:0] x_addr, y_addr;
    logic [15:0] len;
    logic        busy, done, tile_start, tile_first;
    logic [31:0] t_x_addr, t_y_addr;
    logic [15:0] t_x_len, t_y_len, t_skip, t_idx;

    int checks   = 0;
    int failures = 0;

    fir_tile_sched #(.NB_TAPS(50), .TILE_LEN(256)) dut (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .start_i(start),
        .x_addr_i(x_addr), .y_addr_i(y_addr), .signal_length_i(len),
        .tile_done_i(tile_done), .busy_o(busy), .done_o(done),
        .tile_start_o(tile_start), .tile_first_o(tile_first),
        .tile_x_addr_o(t_x_addr), .tile_x_len_o(t_x_len),
        .tile_y_addr_o(t_y_addr), .tile_y_len_o(t_y_len),
        .tile_skip_o(t_skip), .tile_idx_o(t_idx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Reference model: phase 0 idle, 1 tile being started, 2 tile in flight, 3 job finished.
    int          m_phase = 0, m_k = 0, m_len = 0;
    logic [31:0] m_x = '0, m_y = '0;
    bit          live = 1'b0;

    always @(posedge clk) begin
        live <= 1'b1;
        if (!rst_n || clear) begin
            m_phase <= 0;
            m_k     <= 0;
        end else begin
            case (m_phase)
                0: if (start) begin
                    m_x <= x_addr; m_y <= y_addr; m_len <= int'(len); m_k <= 0;
                    m_phase <= (len == 0) ? 3 : 1;
                end
                1: m_phase <= 2;
                2: if (tile_done) begin
                    m_k     <= m_k + 1;
                    m_phase <= ((m_k + 1) * TL >= m_len) ? 3 : 1;
                end
                default: m_phase <= 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (live) begin
            int off, cur, skip;
            chk("m_busy",  {31'd0, busy},       {31'd0, m_phase != 0});
            chk("m_done",  {31'd0, done},       {31'd0, m_phase == 3});
            chk("m_start", {31'd0, tile_start}, {31'd0, m_phase == 1});
            chk("m_first", {31'd0, tile_first}, {31'd0, (m_phase != 0) && (m_k == 0)});
            if (m_phase == 1 || m_phase == 2) begin
                off  = m_k * TL;
                cur  = (m_len - off > TL) ? TL : m_len - off;
                skip = (off == 0) ? 0 : HE;
                chk("m_x_addr", t_x_addr, m_x + 32'(2 * (off - skip)));
                chk("m_x_len",  {16'd0, t_x_len}, 32'((cur + skip + 1) / 2));
                chk("m_y_addr", t_y_addr, m_y + 32'(2 * off));
                chk("m_y_len",  {16'd0, t_y_len}, 32'((cur + 1) / 2));
                chk("m_skip",   {16'd0, t_skip},  32'(skip));
                chk("m_idx",    {16'd0, t_idx},   32'(m_k));
            end
        end
    end

    task automatic do_start(input logic [31:0] xa, input logic [31:0] ya, input logic [15:0] l);
        @(posedge clk); #1;
        x_addr = xa; y_addr = ya; len = l; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic pulse_done();
        @(posedge clk); #1; tile_done = 1'b1;
        @(posedge clk); #1; tile_done = 1'b0;
    endtask

    task automatic issue_check(input string n, input logic [31:0] xa, input int xl,
                               input logic [31:0] ya, input int yl, input int sk, input int ix);
        @(negedge clk);
        chk({n, "_start"}, {31'd0, tile_start}, 32'd1);
        chk({n, "_first"}, {31'd0, tile_first}, {31'd0, ix == 0});
        chk({n, "_xaddr"}, t_x_addr, xa);
        chk({n, "_xlen"},  {16'd0, t_x_len}, 32'(xl));
        chk({n, "_yaddr"}, t_y_addr, ya);
        chk({n, "_ylen"},  {16'd0, t_y_len}, 32'(yl));
        chk({n, "_skip"},  {16'd0, t_skip},  32'(sk));
        chk({n, "_idx"},   {16'd0, t_idx},   32'(ix));
    endtask

    task automatic done_check(input string n);
        @(negedge clk);
        chk({n, "_done"},  {31'd0, done}, 32'd1);
        chk({n, "_nostart"}, {31'd0, tile_start}, 32'd0);
    endtask

    task automatic check_zero(input string n);
        @(negedge clk);
        chk({n, "_busy"},  {31'd0, busy}, 32'd0);
        chk({n, "_done"},  {31'd0, done}, 32'd0);
        chk({n, "_start"}, {31'd0, tile_start}, 32'd0);
        chk({n, "_first"}, {31'd0, tile_first}, 32'd0);
        chk({n, "_xaddr"}, t_x_addr, 32'd0);
        chk({n, "_lens"},  {t_x_len, t_y_len}, 32'd0);
        chk({n, "_yaddr"}, t_y_addr, 32'd0);
        chk({n, "_skipidx"}, {t_skip, t_idx}, 32'd0);
    endtask

    task automatic abort_and_rerun(input string n, input bit use_reset);
        do_start(32'h1000, 32'h2000, 16'd600);
        issue_check({n, "_t0"}, 32'h1000, 128, 32'h2000, 128, 0, 0);
        pulse_done();
        issue_check({n, "_t1"}, 32'h119C, 153, 32'h2200, 128, 50, 1);
        @(posedge clk); #1;
        if (use_reset) rst_n = 1'b0; else clear = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1; clear = 1'b0;
        check_zero({n, "_idle"});
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk({n, "_nodone"}, {31'd0, done}, 32'd0);
        end
        do_start(32'h1000, 32'h2000, 16'd100);
        issue_check({n, "_rerun"}, 32'h1000, 50, 32'h2000, 50, 0, 0);
        pulse_done();
        done_check({n, "_rerun"});
    endtask

    initial begin
        rst_n = 1'b0; clear = 1'b0; start = 1'b0; tile_done = 1'b0;
        x_addr = '0; y_addr = '0; len = '0;
        repeat (2) @(posedge clk);
        check_zero("reset");
        @(posedge clk); #1 rst_n = 1'b1;

        // single tile, with a tile_done that lands in the ISSUE cycle
        do_start(32'h1000, 32'h2000, 16'd100);
        issue_check("s1", 32'h1000, 50, 32'h2000, 50, 0, 0);
        tile_done = 1'b1;
        @(posedge clk); #1 tile_done = 1'b0;
        @(negedge clk);
        chk("s1_issue_done_ignored", {30'd0, busy, done}, 32'd2);
        pulse_done();
        done_check("s1");

        // back-to-back three-tile job with a stray start in tile 1
        do_start(32'h1000, 32'h2000, 16'd600);
        issue_check("s2_t0", 32'h1000, 128, 32'h2000, 128, 0, 0);
        pulse_done();
        issue_check("s2_t1", 32'h119C, 153, 32'h2200, 128, 50, 1);
        @(posedge clk); #1;
        x_addr = 32'hDEAD_0000; y_addr = 32'hBEEF_0000; len = 16'd5; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        pulse_done();
        issue_check("s2_t2", 32'h139C, 69, 32'h2400, 44, 50, 2);
        pulse_done();
        done_check("s2");

        // odd remainder
        do_start(32'h1000, 32'h2000, 16'd257);
        issue_check("s3_t0", 32'h1000, 128, 32'h2000, 128, 0, 0);
        pulse_done();
        issue_check("s3_t1", 32'h119C, 26, 32'h2200, 1, 50, 1);
        pulse_done();
        done_check("s3");

        // zero-length job
        do_start(32'h1000, 32'h2000, 16'd0);
        @(negedge clk);
        chk("s4_done",  {31'd0, done}, 32'd1);
        chk("s4_busy",  {31'd0, busy}, 32'd1);
        chk("s4_start", {31'd0, tile_start}, 32'd0);
        @(negedge clk);
        chk("s4_idle",  {30'd0, busy, done}, 32'd0);

        // tile_done while idle
        pulse_done();
        @(negedge clk);
        chk("s5_idle_done", {30'd0, busy, tile_start}, 32'd0);

        abort_and_rerun("s6_clear", 1'b0);
        abort_and_rerun("s7_reset", 1'b1);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
